// File: rtl/frame_reader_pkg.sv
// Shared types for the frame buffer read sequencer: FSM states, buffered pixel record, gray weights.
package frame_reader_pkg;

    localparam int PIX_W = 24;

    localparam logic [15:0] GRAY_R = 16'd77;
    localparam logic [15:0] GRAY_G = 16'd150;
    localparam logic [15:0] GRAY_B = 16'd29;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_t;

    localparam int PIX_BITS = $bits(pix_t);

    // Weights sum to 256, so the 16-bit sum cannot overflow for 8-bit channels.
    function automatic logic [PIX_W-1:0] to_gray(input logic [PIX_W-1:0] rgb);
        logic [15:0] y;
        y = GRAY_R * {8'd0, rgb[23:16]} + GRAY_G * {8'd0, rgb[15:8]} + GRAY_B * {8'd0, rgb[7:0]};
        return {y[15:8], y[15:8], y[15:8]};
    endfunction

endpackage

// File: rtl/frame_reader_pixel_skid_fifo.sv
// Two-entry pixel FIFO, head is entry 0; zero latency from register to head, one cycle push-to-visible.
// Never pushed while full: the reader's credit check guarantees a free slot for every read in flight.
module pixel_skid_fifo
    import frame_reader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [PIX_BITS-1:0] push_pix,
    input  logic                pop,
    output logic [PIX_BITS-1:0] head,
    output logic [1:0]          count
);

    pix_t entry0, entry1;
    logic pop_eff;

    assign pop_eff = pop && (count != 2'd0);
    assign head    = entry0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            if (pop_eff) begin
                entry0 <= (count == 2'd2) ? entry1 : pix_t'(push_pix);
                if (count == 2'd2 && push)
                    entry1 <= push_pix;
            end else if (push) begin
                if (count == 2'd0)
                    entry0 <= push_pix;
                else
                    entry1 <= push_pix;
            end
            count <= count + {1'b0, push} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame buffer reader to valid/ready stream; first pixel 3 cycles after start, lossless under backpressure.
// Define FRAME_READER_GRAY_EN to emit luma replicated on all three channels instead of raw RGB.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int RGB_WIDTH    = 24,
    parameter int IMG_WIDTH    = 176,
    parameter int IMG_HEIGHT   = 240,
    parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [RGB_WIDTH-1:0]  rData,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RGB_WIDTH-1:0]  m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof
);

    localparam int X_WIDTH = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    state_t               state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [X_WIDTH-1:0]    x;
    logic                  inflight;
    logic                  rd_sof, rd_eol, rd_eof;
    logic                  last_addr, last_x;
    logic                  pop, credit;
    logic [2:0]            occ;
    logic [1:0]            fifo_count;
    logic [PIX_BITS-1:0]   head_bits;
    pix_t                  wr_pix, head;

    assign last_addr = (addr == ADDR_WIDTH'(TOTAL_PIXELS - 1));
    assign last_x    = (x == X_WIDTH'(IMG_WIDTH - 1));
    assign pop       = m_valid && m_ready;

    // A slot must be free for every read already issued, counting the one leaving this cycle.
    assign occ    = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit = occ < ({2'b00, pop} + 3'd2);

    always_comb begin
        state_nxt = state;
        oe        = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ: begin
                oe = credit;
                if (credit && last_addr) state_nxt = DRAIN;
            end
            // Leave as the last pixel pops so done lands one cycle after the eof handshake.
            DRAIN: if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                       state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            x        <= '0;
            inflight <= 1'b0;
            rd_sof   <= 1'b0;
            rd_eol   <= 1'b0;
            rd_eof   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= oe;
            rd_sof   <= (addr == '0);
            rd_eol   <= last_x;
            rd_eof   <= last_addr;
            if (state == IDLE && start) begin
                addr <= '0;
                x    <= '0;
            end else if (oe) begin
                addr <= last_addr ? '0 : addr + 1'b1;
                x    <= last_x ? '0 : x + 1'b1;
            end
        end
    end

    always_comb begin
        wr_pix     = '0;
`ifdef FRAME_READER_GRAY_EN
        wr_pix.data = to_gray(rData);
`else
        wr_pix.data = rData;
`endif
        wr_pix.sof = rd_sof;
        wr_pix.eol = rd_eol;
        wr_pix.eof = rd_eof;
    end

    pixel_skid_fifo u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (inflight),
        .push_pix (wr_pix),
        .pop      (pop),
        .head     (head_bits),
        .count    (fifo_count)
    );

    assign head    = head_bits;
    assign rAddr   = addr;
    assign busy    = (state == READ) || (state == DRAIN);
    assign done    = (state == DONE);
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = head.data;
    assign m_sof   = head.sof && m_valid;
    assign m_eol   = head.eol && m_valid;
    assign m_eof   = head.eof && m_valid;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a 4x3 image with a synchronous-read frame buffer model and a pixel scoreboard.
module tb_frame_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clk, reset, start, m_ready;
    logic          busy, done, oe, m_valid, m_sof, m_eol, m_eof;
    logic [AW-1:0] rAddr;
    logic [23:0]   rData, m_data;

    logic [23:0] mem [0:N-1];
    logic [26:0] exp_q [$];

    int checks = 0, failures = 0;
    int cyc = 0, beat_cnt = 0, done_cnt = 0, eof_cyc = -100, sof_cyc = -100;
    int occ = 0;
    bit infl = 1'b0;

    frame_reader #(
        .RGB_WIDTH  (24),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .oe      (oe),
        .rAddr   (rAddr),
        .rData   (rData),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (oe) rData <= mem[rAddr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_data(input logic [23:0] rgb);
`ifdef FRAME_READER_GRAY_EN
        int y;
        logic [7:0] yy;
        y  = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]);
        yy = 8'(y >> 8);
        return {yy, yy, yy};
`else
        return rgb;
`endif
    endfunction

    task automatic push_frame();
        for (int i = 0; i < N; i++)
            exp_q.push_back({exp_data(mem[i]), i == 0, (i % W) == W - 1, i == N - 1});
    endtask

    // One clock: sample at the falling edge, then return just after the next rising edge.
    task automatic step();
        bit pop;
        @(negedge clk);
        pop = m_valid && m_ready;
        if (pop) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("pixel", {m_data, m_sof, m_eol, m_eof}, exp_q.pop_front());
            beat_cnt++;
            if (m_eof) eof_cyc = cyc;
            if (m_sof) sof_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_eof", cyc - eof_cyc, 1);
        end
        if (oe) chk("credit", (occ + int'(infl)) < (2 + int'(pop)), 1);
        occ  = occ + int'(infl) - int'(pop);
        infl = oe;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int budget, input bit rnd);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        m_ready = 1'b1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int base, d0;
        logic [23:0] held;
        bit oe_hi;

        reset = 1'b1; start = 1'b0; m_ready = 1'b1; rData = '0;
        for (int i = 0; i < N; i++) mem[i] = 24'(i);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, oe, m_valid, m_sof, m_eol, m_eof, rAddr, m_data}, 0);
        reset = 1'b0;
        step();

        // Full-rate frame with latency and marker checks
        base = beat_cnt;
        push_frame();
        kick();
        chk("oe_cycle1", oe, 1);
        chk("raddr_cycle1", rAddr, 0);
        chk("valid_cycle1", m_valid, 0);
        step();
        chk("valid_cycle2", m_valid, 0);
        step();
        chk("valid_cycle3", m_valid, 1);
        chk("first_sof", m_sof, 1);
        run_until_done(100, 0);
        chk("beats_f1", beat_cnt - base, N);
        chk("span_f1", eof_cyc - sof_cyc, N - 1);
        chk("queue_empty_f1", exp_q.size(), 0);

        // Random backpressure with random pixel data
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        base = beat_cnt;
        push_frame();
        kick();
        run_until_done(500, 1);
        chk("beats_rand", beat_cnt - base, N);
        chk("queue_empty_rand", exp_q.size(), 0);

        // Ten-cycle stall mid-frame, with a stray start during the stall
        for (int i = 0; i < N; i++) mem[i] = 24'(i + 16'h100);
        base = beat_cnt;
        d0 = done_cnt;
        push_frame();
        kick();
        for (int i = 0; i < 50 && beat_cnt - base < 3; i++) step();
        m_ready = 1'b0;
        oe_hi = 1'b0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            step();
            if (i == 2) held = m_data;
            if (i >= 3) oe_hi = oe_hi | oe;
        end
        start = 1'b0;
        chk("stall_oe", oe_hi, 0);
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
        chk("stall_buffered", int'(rAddr) - (beat_cnt - base), 2);
        m_ready = 1'b1;
        run_until_done(100, 0);
        repeat (20) step();
        chk("beats_stall", beat_cnt - base, N);
        chk("single_done", done_cnt - d0, 1);
        chk("idle_busy", busy, 0);

        // Reset at beat 5, then a clean restart from address 0
        for (int i = 0; i < N; i++) mem[i] = 24'(i * 3 + 7);
        base = beat_cnt;
        push_frame();
        kick();
        for (int i = 0; i < 50 && beat_cnt - base < 5; i++) step();
        chk("pre_reset_beats", beat_cnt - base, 5);
        reset = 1'b1;
        #1;
        chk("reset_mid", {busy, done, oe, m_valid, m_sof, m_eol, m_eof, rAddr, m_data}, 0);
        exp_q.delete();
        occ = 0;
        infl = 1'b0;
        step();
        reset = 1'b0;
        step();
        base = beat_cnt;
        push_frame();
        kick();
        chk("restart_raddr", rAddr, 0);
        step();
        step();
        chk("restart_first", {m_valid, m_sof, m_data}, {1'b1, 1'b1, exp_data(mem[0])});
        run_until_done(100, 0);
        chk("beats_restart", beat_cnt - base, N);

        // Saturated colours: red and white
        mem[0] = 24'hFF0000;
        mem[1] = 24'hFFFFFF;
        base = beat_cnt;
        push_frame();
        kick();
        step();
        step();
`ifdef FRAME_READER_GRAY_EN
        chk("red_pixel", m_data, 24'h4C4C4C);
`else
        chk("red_pixel", m_data, 24'hFF0000);
`endif
        m_ready = 1'b0;
        step();
        m_ready = 1'b1;
        step();
        chk("white_pixel", m_data, 24'hFFFFFF);
        run_until_done(100, 0);
        chk("beats_color", beat_cnt - base, N);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
